// File: rtl/rvdmi_pkg.sv
// Shared types and encodings for the DMI request sequencer.
// Status codes follow the DTM dmistat/op encoding.
package rvdmi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    localparam logic [1:0] DMI_OK     = 2'd0;
    localparam logic [1:0] DMI_FAILED = 2'd2;
    localparam logic [1:0] DMI_BUSY   = 2'd3;

    // Strobe pair encoding is {wr, rd}
    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    function automatic logic [1:0] busy_merge(input logic [1:0] s);
        return (s == DMI_FAILED) ? DMI_FAILED : DMI_BUSY;
    endfunction

endpackage

// File: rtl/rvdmi_timeout.sv
// Saturating access timer; expired flags the cycle whose count
// completes TIMEOUT_CYCLES busy cycles. Zero disables it.
module rvdmi_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW =
        (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] MAX = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST =
        CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic ENABLED = (TIMEOUT_CYCLES != 0);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != MAX) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = ENABLED && enable && (cnt >= LAST);

endmodule

// File: rtl/rvdmi_sequencer.sv
// DTM-side DMI sequencer: one outstanding bus access with
// busy/failed sticky status, timeout and hard-reset abort.
module rvdmi_sequencer
    import rvdmi_pkg::*;
#(
    parameter int unsigned AWIDTH         = 7,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [2:0]  IDLE_HINT      = 3'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_wr_en,
    input  logic              req_rd_en,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              dmi_reset,
    input  logic              dmi_hard_reset,
    output logic              dmi_req_valid,
    input  logic              dmi_req_ready,
    output logic              dmi_req_write,
    output logic [AWIDTH-1:0] dmi_req_addr,
    output logic [31:0]       dmi_req_wdata,
    input  logic              dmi_rsp_valid,
    input  logic              dmi_rsp_error,
    input  logic [31:0]       dmi_rsp_rdata,
    output logic [31:0]       rd_data,
    output logic [1:0]        rd_status,
    output logic [1:0]        dmi_stat,
    output logic [2:0]        idle,
    output logic              busy
);

    state_e            state, state_d;
    logic              write_d;
    logic [AWIDTH-1:0] addr_d;
    logic [31:0]       wdata_d;
    logic [31:0]       rdata_d;
    logic [1:0]        rs_d;
    logic [1:0]        stat_d;
    logic [1:0]        stat_base;
    logic [1:0]        op;
    logic              strobe;
    logic              launch;
    logic              expired;

    rvdmi_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (launch | dmi_hard_reset),
        .enable (state != ST_IDLE),
        .expired(expired)
    );

    assign op     = {req_wr_en, req_rd_en};
    assign strobe = (op == OP_READ) || (op == OP_WRITE);

    // dmi_reset clears ahead of anything else decided this cycle
    assign stat_base = dmi_reset ? DMI_OK : dmi_stat;

    always_comb begin
        state_d = state;
        write_d = dmi_req_write;
        addr_d  = dmi_req_addr;
        wdata_d = dmi_req_wdata;
        rdata_d = rd_data;
        rs_d    = rd_status;
        stat_d  = dmi_stat;
        launch  = 1'b0;
        if (dmi_hard_reset) begin
            state_d = ST_IDLE;
            rs_d    = DMI_OK;
            stat_d  = DMI_OK;
        end else begin
            stat_d = stat_base;
            if (state != ST_IDLE && strobe) begin
                stat_d = busy_merge(stat_base);
                rs_d   = DMI_BUSY;
            end
            unique case (state)
                ST_IDLE: begin
                    if (strobe) begin
                        if (stat_base == DMI_OK) begin
                            state_d = ST_REQ;
                            launch  = 1'b1;
                            write_d = (op == OP_WRITE);
                            addr_d  = req_addr;
                            wdata_d = req_wdata;
                        end else begin
                            rs_d = stat_base;
                        end
                    end
                end
                ST_REQ: begin
                    if (expired) begin
                        state_d = ST_IDLE;
                        rs_d    = DMI_FAILED;
                        stat_d  = DMI_FAILED;
                    end else if (dmi_req_ready) begin
                        state_d = ST_RSP;
                    end
                end
                ST_RSP: begin
                    // A response in the expiry cycle still completes the access
                    if (dmi_rsp_valid) begin
                        state_d = ST_IDLE;
                        if (dmi_rsp_error) begin
                            rs_d   = DMI_FAILED;
                            stat_d = DMI_FAILED;
                        end else begin
                            rs_d = DMI_OK;
                            if (!dmi_req_write) begin
                                rdata_d = dmi_rsp_rdata;
                            end
                        end
                    end else if (expired) begin
                        state_d = ST_IDLE;
                        rs_d    = DMI_FAILED;
                        stat_d  = DMI_FAILED;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            dmi_req_write <= 1'b0;
            dmi_req_addr  <= '0;
            dmi_req_wdata <= '0;
            rd_data       <= '0;
            rd_status     <= DMI_OK;
            dmi_stat      <= DMI_OK;
        end else begin
            state         <= state_d;
            dmi_req_write <= write_d;
            dmi_req_addr  <= addr_d;
            dmi_req_wdata <= wdata_d;
            rd_data       <= rdata_d;
            rd_status     <= rs_d;
            dmi_stat      <= stat_d;
        end
    end

    assign dmi_req_valid = (state == ST_REQ);
    assign busy          = (state != ST_IDLE);
    assign idle          = IDLE_HINT;

endmodule

// File: tb/tb_rvdmi_sequencer.sv
// Directed bench for rvdmi_sequencer with an 8-cycle timeout.
// Expected values are hand-derived per scenario.
module tb_rvdmi_sequencer;

    logic        clk;
    logic        rst;
    logic        req_wr_en;
    logic        req_rd_en;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic        dmi_reset;
    logic        dmi_hard_reset;
    logic        dmi_req_valid;
    logic        dmi_req_ready;
    logic        dmi_req_write;
    logic [6:0]  dmi_req_addr;
    logic [31:0] dmi_req_wdata;
    logic        dmi_rsp_valid;
    logic        dmi_rsp_error;
    logic [31:0] dmi_rsp_rdata;
    logic [31:0] rd_data;
    logic [1:0]  rd_status;
    logic [1:0]  dmi_stat;
    logic [2:0]  idle;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    rvdmi_sequencer #(
        .AWIDTH(7),
        .TIMEOUT_CYCLES(8),
        .IDLE_HINT(3'd1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_wr_en     (req_wr_en),
        .req_rd_en     (req_rd_en),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .dmi_reset     (dmi_reset),
        .dmi_hard_reset(dmi_hard_reset),
        .dmi_req_valid (dmi_req_valid),
        .dmi_req_ready (dmi_req_ready),
        .dmi_req_write (dmi_req_write),
        .dmi_req_addr  (dmi_req_addr),
        .dmi_req_wdata (dmi_req_wdata),
        .dmi_rsp_valid (dmi_rsp_valid),
        .dmi_rsp_error (dmi_rsp_error),
        .dmi_rsp_rdata (dmi_rsp_rdata),
        .rd_data       (rd_data),
        .rd_status     (rd_status),
        .dmi_stat      (dmi_stat),
        .idle          (idle),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [6:0] a, input logic [31:0] d,
                           input logic err);
        req_rd_en = 1'b1;
        req_addr  = a;
        tick();
        req_rd_en = 1'b0;
        chk("rd_req", {dmi_req_valid, dmi_req_write, dmi_req_addr},
            {1'b1, 1'b0, a});
        dmi_req_ready = 1'b1;
        tick();
        dmi_req_ready = 1'b0;
        chk("rd_hs_drop", dmi_req_valid, 1'b0);
        dmi_rsp_valid = 1'b1;
        dmi_rsp_rdata = d;
        dmi_rsp_error = err;
        tick();
        dmi_rsp_valid = 1'b0;
        dmi_rsp_error = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        req_wr_en      = 1'b0;
        req_rd_en      = 1'b0;
        req_addr       = '0;
        req_wdata      = '0;
        dmi_reset      = 1'b0;
        dmi_hard_reset = 1'b0;
        dmi_req_ready  = 1'b0;
        dmi_rsp_valid  = 1'b0;
        dmi_rsp_error  = 1'b0;
        dmi_rsp_rdata  = '0;
        tick();
        tick();
        chk("rst_valid", dmi_req_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rd", {rd_data, rd_status, dmi_stat}, 36'h0);
        chk("rst_idle", idle, 3'd1);
        chk("rst_req", {dmi_req_write, dmi_req_addr, dmi_req_wdata}, 40'h0);
        rst = 1'b0;
        tick();

        // plain read
        do_read(7'h11, 32'hDEADBEEF, 1'b0);
        chk("r1_data", rd_data, 32'hDEADBEEF);
        chk("r1_stat", {rd_status, dmi_stat, busy}, {2'd0, 2'd0, 1'b0});

        // write with 5 stalled cycles, busy strobe in RSP
        req_wr_en = 1'b1;
        req_addr  = 7'h04;
        req_wdata = 32'h1;
        tick();
        req_wr_en = 1'b0;
        req_addr  = 7'h7F;
        req_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            chk("w_stall", {dmi_req_valid, dmi_req_write, dmi_req_addr,
                dmi_req_wdata}, {1'b1, 1'b1, 7'h04, 32'h1});
            tick();
        end
        dmi_req_ready = 1'b1;
        tick();
        dmi_req_ready = 1'b0;
        chk("w_hs", {dmi_req_valid, busy}, {1'b0, 1'b1});
        req_wr_en = 1'b1;
        tick();
        req_wr_en = 1'b0;
        chk("w_busy_strobe", {rd_status, dmi_stat, dmi_req_valid},
            {2'd3, 2'd3, 1'b0});
        dmi_rsp_valid = 1'b1;
        dmi_rsp_rdata = 32'h55;
        tick();
        dmi_rsp_valid = 1'b0;
        chk("w_done", {busy, rd_status, dmi_stat}, {1'b0, 2'd0, 2'd3});
        chk("w_rdata_keep", rd_data, 32'hDEADBEEF);

        // sticky busy blocks, dmi_reset clears
        req_rd_en = 1'b1;
        tick();
        req_rd_en = 1'b0;
        chk("stk_ignored", {busy, rd_status}, {1'b0, 2'd3});
        dmi_reset = 1'b1;
        tick();
        dmi_reset = 1'b0;
        chk("stk_clear", dmi_stat, 2'd0);
        do_read(7'h22, 32'h12345678, 1'b0);
        chk("r2_data", {rd_data, rd_status}, {32'h12345678, 2'd0});

        // error response
        do_read(7'h23, 32'hBAD0BAD0, 1'b1);
        chk("err_stat", {rd_status, dmi_stat}, {2'd2, 2'd2});
        chk("err_data", rd_data, 32'h12345678);

        // dmi_reset with strobe, then timeout
        req_rd_en     = 1'b1;
        req_addr      = 7'h40;
        dmi_reset     = 1'b1;
        dmi_req_ready = 1'b1;
        tick();
        req_rd_en     = 1'b0;
        dmi_reset     = 1'b0;
        chk("to_accept", {busy, dmi_stat}, {1'b1, 2'd0});
        tick();
        dmi_req_ready = 1'b0;
        repeat (6) tick();
        chk("to_pending", busy, 1'b1);
        tick();
        chk("to_fire", {busy, rd_status, dmi_stat}, {1'b0, 2'd2, 2'd2});
        dmi_rsp_valid = 1'b1;
        dmi_rsp_rdata = 32'hFFFF_FFFF;
        tick();
        dmi_rsp_valid = 1'b0;
        chk("late_rsp", {rd_data, rd_status, busy},
            {32'h12345678, 2'd2, 1'b0});
        dmi_reset = 1'b1;
        tick();
        dmi_reset = 1'b0;

        // reserved op
        req_wr_en = 1'b1;
        req_rd_en = 1'b1;
        tick();
        req_wr_en = 1'b0;
        req_rd_en = 1'b0;
        chk("rsvd", {busy, dmi_req_valid, rd_status, dmi_stat},
            {1'b0, 1'b0, 2'd2, 2'd0});

        // hard reset in REQ with a same-cycle strobe
        req_rd_en = 1'b1;
        req_addr  = 7'h30;
        tick();
        chk("hr_req", dmi_req_valid, 1'b1);
        dmi_hard_reset = 1'b1;
        tick();
        dmi_hard_reset = 1'b0;
        req_rd_en      = 1'b0;
        chk("hr_abort", {dmi_req_valid, busy, rd_status, dmi_stat},
            {1'b0, 1'b0, 2'd0, 2'd0});

        // async reset mid-RSP
        req_rd_en = 1'b1;
        req_addr  = 7'h31;
        tick();
        req_rd_en     = 1'b0;
        dmi_req_ready = 1'b1;
        tick();
        dmi_req_ready = 1'b0;
        chk("ar_rsp", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("ar_async", {busy, dmi_req_valid, rd_data, dmi_req_addr},
            {1'b0, 1'b0, 32'h0, 7'h0});
        tick();
        rst = 1'b0;
        tick();
        do_read(7'h11, 32'hCAFEF00D, 1'b0);
        chk("ar_after", {rd_data, rd_status, dmi_stat},
            {32'hCAFEF00D, 2'd0, 2'd0});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
